// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states, step modes and default sizing.
package muldiv_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int CYCLES_DEF = 32;

    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } step_mode_e;

    // Only MULTU and DIVU start an operation; the other two codes are no-ops.
    function automatic logic op_is_valid(input logic [1:0] op_code);
        return (op_code == OP_MULTU) || (op_code == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration shared by multiply and divide.
// acc is {upper half, lower half}, 2*WIDTH bits.
//  MUL: upper = partial product, lower = remaining multiplier bits.
//       Add operand when acc[0] is set, then shift the whole thing right.
//  DIV: upper = partial remainder, lower = dividend bits / quotient bits.
//       Shift left, then subtract the divisor when it fits (restoring).
//       The shifted remainder is WIDTH+1 bits wide. It is always below the
//       divisor after a step, so its top bit never has to be stored.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  step_mode_e         mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] rem_sh_s;

    // Compute a single shift-add or restoring-subtract step.
    always_comb begin
        sum_s    = {(WIDTH+1){1'b0}};
        rem_sh_s = {(WIDTH+1){1'b0}};
        acc_next = acc;
        case (mode)
            MODE_MUL: begin
                if (acc[0]) begin
                    sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
                end else begin
                    sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
                end
                acc_next = {sum_s, acc[WIDTH-1:1]};
            end
            MODE_DIV: begin
                rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
                if (rem_sh_s >= {1'b0, operand}) begin
                    acc_next = {rem_sh_s[WIDTH-1:0] - operand, acc[WIDTH-2:0], 1'b1};
                end else begin
                    acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                acc_next = acc;
            end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULTU/DIVU unit for the EX stage; owns HI/LO and
// drives the pipeline stall while an operation is in flight.
// Optional feature: define MULDIV_SIGNED_EN to add the is_signed input
// (signed multiply/divide via magnitude arithmetic plus sign fix-up).
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CYCLES = CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
`ifdef MULDIV_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0]   ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_e             state_r;
    state_e             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;          // raw dividend, needed for divide-by-zero
    logic [WIDTH-1:0]   div_r;        // magnitude of multiplier / divisor
    logic [2*WIDTH-1:0] acc_r;
    logic               neg_res_r;    // operand signs differ
    logic               neg_rem_r;    // dividend was negative
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               signed_in_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               request_s;
    logic               accept_s;
    logic               last_step_s;
    step_mode_e         mode_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

`ifdef MULDIV_SIGNED_EN
    assign signed_in_s = is_signed;
`else
    assign signed_in_s = 1'b0;
`endif

    assign request_s   = start & op_is_valid(op) & (state_r == S_IDLE);
    assign accept_s    = request_s;
    assign last_step_s = (state_r == S_RUN) && (cnt_r == LAST_CNT);

    assign stall = request_s | (state_r == S_RUN) | (state_r == S_DONE);
    assign busy  = busy_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

    // Convert incoming operands to magnitudes when a signed operation is requested.
    always_comb begin
        neg_a_s = signed_in_s & src_a[WIDTH-1];
        neg_b_s = signed_in_s & src_b[WIDTH-1];
        if (neg_a_s) begin
            mag_a_s = (~src_a) + ONE_W;
        end else begin
            mag_a_s = src_a;
        end
        if (neg_b_s) begin
            mag_b_s = (~src_b) + ONE_W;
        end else begin
            mag_b_s = src_b;
        end
    end

    // Select the step flavour from the latched operation.
    always_comb begin
        mode_s = MODE_MUL;
        case (op_r)
            OP_MULTU: mode_s = MODE_MUL;
            OP_DIVU:  mode_s = MODE_DIV;
            default:  mode_s = MODE_MUL;
        endcase
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc      (acc_r),
        .operand  (div_r),
        .mode     (mode_s),
        .acc_next (step_acc_s)
    );

    // Form the HI/LO values from the final step, applying sign fix-up and divide-by-zero.
    always_comb begin
        prod_s   = step_acc_s;
        quot_s   = step_acc_s[WIDTH-1:0];
        rem_s    = step_acc_s[2*WIDTH-1:WIDTH];
        res_hi_s = hi_r;
        res_lo_s = lo_r;
        case (op_r)
            OP_MULTU: begin
                if (neg_res_r) begin
                    prod_s = (~step_acc_s) + ONE_2W;
                end else begin
                    prod_s = step_acc_s;
                end
                res_hi_s = prod_s[2*WIDTH-1:WIDTH];
                res_lo_s = prod_s[WIDTH-1:0];
            end
            OP_DIVU: begin
                if (div_r == ZERO_W) begin
                    res_hi_s = a_r;
                    res_lo_s = ONES_W;
                end else begin
                    if (neg_res_r) begin
                        quot_s = (~step_acc_s[WIDTH-1:0]) + ONE_W;
                    end else begin
                        quot_s = step_acc_s[WIDTH-1:0];
                    end
                    if (neg_rem_r) begin
                        rem_s = (~step_acc_s[2*WIDTH-1:WIDTH]) + ONE_W;
                    end else begin
                        rem_s = step_acc_s[2*WIDTH-1:WIDTH];
                    end
                    res_hi_s = rem_s;
                    res_lo_s = quot_s;
                end
            end
            default: begin
                res_hi_s = hi_r;
                res_lo_s = lo_r;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last step, DONE -> IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_step_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, write HI/LO on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= ZERO_CNT;
            op_r      <= 2'b00;
            a_r       <= ZERO_W;
            div_r     <= ZERO_W;
            acc_r     <= ZERO_2W;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (next_state_s != S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r      <= op;
                        a_r       <= src_a;
                        div_r     <= mag_b_s;
                        acc_r     <= {ZERO_W, mag_a_s};
                        neg_res_r <= neg_a_s ^ neg_b_s;
                        neg_rem_r <= neg_a_s;
                        cnt_r     <= ZERO_CNT;
                    end
                end
                S_RUN: begin
                    acc_r <= step_acc_s;
                    cnt_r <= cnt_r + ONE_CNT;
                    if (last_step_s) begin
                        hi_r   <= res_hi_s;
                        lo_r   <= res_lo_s;
                        done_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    cnt_r <= ZERO_CNT;
                end
                default: begin
                    cnt_r <= ZERO_CNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a cycle-level behavioural model
// (accept time + plain 64-bit arithmetic) checked every cycle, directed
// cases with literal expectations, then randomized traffic.
module tb_mul_div_unit;

    localparam int W   = 32;
    localparam int CYC = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          is_signed_v;
    logic          stall;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;
    int t_issue = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul_div_unit #(.WIDTH(W), .CYCLES(CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
`ifdef MULDIV_SIGNED_EN
        .is_signed (is_signed_v),
`endif
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic sgn);
        longint sa, sb, q, rm;
        logic [63:0] r;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        if (o == 2'b01) begin
            r = 64'(sa * sb);
        end else if (b == 32'h0) begin
            r = {a, 32'hFFFF_FFFF};
        end else begin
            q  = sa / sb;
            rm = sa % sb;
            r  = {rm[31:0], q[31:0]};
        end
        return r;
    endfunction

    // ---------------- per-cycle model and compare ----------------
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [63:0] m_res    = 64'h0;
    logic [63:0] m_pend   = 64'h0;
    bit          e_run, e_done, e_req;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_run  = m_active && (cyc >= m_t + 1) && (cyc <= m_t + CYC + 1);
            e_done = m_active && (cyc == m_t + CYC + 1);
            e_req  = !e_run && (start === 1'b1) && (op == 2'b01 || op == 2'b10);
            if (e_done) m_res = m_pend;
            check("stall", 64'(stall), 64'(e_req || e_run));
            check("busy",  64'(busy),  64'(e_run));
            check("done",  64'(done),  64'(e_done));
            check("hi",    64'(hi),    64'(m_res[63:32]));
            check("lo",    64'(lo),    64'(m_res[31:0]));
            if (rst) begin
                m_active = 1'b0;
                m_res    = 64'h0;
            end else if (e_req) begin
                m_active = 1'b1;
                m_t      = cyc;
                m_pend   = ref_result(op, src_a, src_b, is_signed_v & SIGNED_BUILD);
            end else if (e_done) begin
                m_active = 1'b0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = b; is_signed_v = s;
        t_issue = cyc;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom; is_signed_v = 1'($urandom);
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        #2;
        if (dc < 0) begin
            n_total++;
            $display("FAIL done_timeout: got no done, expected done within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    int dc, tt, npulse;

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = 32'h0; src_b = 32'h0; is_signed_v = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #2;
        check("reset_hi",   64'(hi),   64'h0);
        check("reset_lo",   64'(lo),   64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);

        // MULTU 7*6: timing and value
        issue(2'b01, 32'd7, 32'd6, 1'b0);
        tt = t_issue;
        wait_done(dc);
        check("t1_done_cycle", 64'(dc), 64'(tt + 33));
        check("t1_hi", 64'(hi), 64'h0);
        check("t1_lo", 64'(lo), 64'd42);
        @(negedge clk); #2;
        check("t1_busy_low", 64'(busy), 64'h0);
        check("t1_stall_low", 64'(stall), 64'h0);

        // Max operands
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(dc);
        check("t2_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("t2_lo", 64'(lo), 64'h1);

        // Divide and divide-by-zero
        issue(2'b10, 32'd100, 32'd7, 1'b0);
        wait_done(dc);
        check("t3_div_lo", 64'(lo), 64'd14);
        check("t3_div_hi", 64'(hi), 64'd2);
        issue(2'b10, 32'd5, 32'd0, 1'b0);
        wait_done(dc);
        check("t3_div0_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
        check("t3_div0_hi", 64'(hi), 64'd5);

        // Start while busy is ignored; exactly one done pulse
        issue(2'b01, 32'd1234, 32'd5678, 1'b0);
        repeat (9) @(posedge clk);
        #1 start = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) npulse++;
        end
        #2;
        check("t4_done_pulses", 64'(npulse), 64'd1);
        check("t4_hi", 64'(hi), 64'h0);
        check("t4_lo", 64'(lo), 64'd7006652);
        @(posedge clk); #1 start = 1'b1; op = 2'b00;
        @(negedge clk); #2;
        check("t4_noop00_stall", 64'(stall), 64'h0);
        @(posedge clk); #1 op = 2'b11;
        @(negedge clk); #2;
        check("t4_noop11_stall", 64'(stall), 64'h0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); #2;
        check("t4_noop_busy", 64'(busy), 64'h0);

        // Reset mid-operation, then a new start at T+17
        issue(2'b01, 32'd3, 32'd5, 1'b0);
        tt = t_issue;
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #2;
        check("t5_rst_cycle", 64'(cyc), 64'(tt + 16));
        check("t5_rst_hi",   64'(hi),   64'h0);
        check("t5_rst_lo",   64'(lo),   64'h0);
        check("t5_rst_busy", 64'(busy), 64'h0);
        issue(2'b10, 32'd1000, 32'd33, 1'b0);
        check("t5_restart_cycle", 64'(t_issue), 64'(tt + 17));
        wait_done(dc);
        check("t5_done_cycle", 64'(dc), 64'(t_issue + 33));
        check("t5_lo", 64'(lo), 64'd30);
        check("t5_hi", 64'(hi), 64'd10);

`ifdef MULDIV_SIGNED_EN
        issue(2'b01, 32'hFFFF_FFFA, 32'd7, 1'b1);
        wait_done(dc);
        check("t6_smul_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check("t6_smul_lo", 64'(lo), 64'h0000_0000_FFFF_FFD6);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(dc);
        check("t6_sdiv_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        check("t6_sdiv_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
`endif

        // Randomized traffic, including ignored starts, no-ops and resets
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst         = ($urandom_range(0, 199) == 0);
            start       = ($urandom_range(0, 3) == 0);
            op          = 2'($urandom_range(0, 3));
            src_a       = $urandom;
            is_signed_v = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       src_b = 32'h0;
                1:       src_b = 32'($urandom_range(1, 15));
                2:       src_b = $urandom;
                default: src_b = $urandom >> $urandom_range(0, 31);
            endcase
        end
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
